pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, optional skid buffer and synchronous flush. It is the general successor to the fixed-field inter-stage latches between ID/EX/MEM/WB: the payload is one packed WIDTH-bit bus, and stalls propagate by backpressure rather than by global enables. With SKID=1 it breaks the ready path so no combinational ready or data path crosses the stage. It sits between any two pipeline stages.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_slot.sv | 35 +++
 rtl/pipe_stage_skid.sv | 107 ++++++++++
 tb/tb_pipe_stage_skid.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register.
//   stage_state_e : stage state, encoded directly as {S.valid, M.valid}
//   SKID_OFF/ON   : values for the SKID mode parameter
//   count_entries : number of held entries from the two valid bits
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } stage_state_e;

  localparam int SKID_OFF = 0;
  localparam int SKID_ON  = 1;

  function automatic logic [1:0] count_entries(input logic s_v, input logic m_v);
    return {1'b0, s_v} + {1'b0, m_v};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: WIDTH-bit data register plus its valid bit.
//   clk, rst    : clock, synchronous active-low reset (clears data and valid)
//   load        : capture d and mark valid
//   clear       : drop valid (data kept, stale)
//   flush       : drop valid, wins over load/clear
//   d / q       : data in / held data
//   valid       : entry holds live data
module pipe_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      // A load killed by flush is not captured, so discarded data never
      // shows up even as stale payload.
      if (load && !flush) q <= d;
      if (flush)      valid <= 1'b0;
      else if (load)  valid <= 1'b1;
      else if (clear) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional skid entry
// and synchronous flush.
//   WIDTH     : payload width
//   SKID      : 1 = two entries, registered in_ready; 0 = one entry,
//               combinational in_ready
//   clk, rst  : clock, synchronous active-low reset
//   flush     : kill all held entries at the next edge
//   in_valid / in_ready / in_data    : upstream handshake
//   out_valid / out_ready / out_data : downstream handshake
//   occupancy : entries held (0..2)
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic             m_v, s_v;
  logic [WIDTH-1:0] m_q, s_q, m_d;
  logic             m_load, m_clear, s_load, s_clear;
  logic             in_xfer, out_xfer;
  stage_state_e     state;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = m_v & out_ready;

  // The state register is the pair of slot valid bits; no separate copy.
  assign state = stage_state_e'({s_v, m_v});

  pipe_slot #(.WIDTH(WIDTH)) u_m (
    .clk   (clk),
    .rst   (rst),
    .load  (m_load),
    .clear (m_clear),
    .flush (flush),
    .d     (m_d),
    .q     (m_q),
    .valid (m_v)
  );

  generate
    if (SKID == SKID_ON) begin : g_skid
      pipe_slot #(.WIDTH(WIDTH)) u_s (
        .clk   (clk),
        .rst   (rst),
        .load  (s_load),
        .clear (s_clear),
        .flush (flush),
        .d     (in_data),
        .q     (s_q),
        .valid (s_v)
      );
      // Straight from a flop: breaks the out_ready -> in_ready path.
      assign in_ready = ~s_v;
    end else begin : g_noskid
      logic unused_s;
      assign s_v      = 1'b0;
      assign s_q      = '0;
      assign unused_s = s_load ^ s_clear;
      assign in_ready = ~m_v | out_ready;
    end
  endgenerate

  // Next-state / slot control. S only ever refills M, so FIFO order holds.
  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    m_d     = in_data;
    if (SKID == SKID_ON) begin
      case (state)
        ST_EMPTY: m_load = in_xfer;
        ST_FULL: begin
          m_load  = in_xfer & out_xfer;
          m_clear = out_xfer & ~in_xfer;
          s_load  = in_xfer & ~out_xfer;
        end
        ST_SKID: begin
          m_d     = s_q;
          m_load  = out_xfer;
          s_clear = out_xfer;
        end
        default: ;
      endcase
    end else begin
      m_load  = in_xfer;
      m_clear = out_xfer & ~in_xfer;
    end
  end

  assign out_valid = m_v;
  assign out_data  = m_q;
  assign occupancy = count_entries(s_v, m_v);

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut1: SKID=1, dut0: SKID=0
  logic        fl1, iv1, or1, ir1, ov1;
  logic [31:0] id1, od1;
  logic [1:0]  oc1;
  logic        fl0, iv0, or0, ir0, ov0;
  logic [31:0] id0, od0;
  logic [1:0]  oc0;

  pipe_stage_skid #(.WIDTH(32), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
    .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .occupancy(oc1));

  pipe_stage_skid #(.WIDTH(32), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
    .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .occupancy(oc0));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each stage is a FIFO of capacity 2 (skid) or 1.
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  bit known = 0;
  bit hold1 = 0, hold0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, then advance one clock.
  task automatic cycle();
    bit mir1, mir0, xi1, xo1, xi0, xo0;
    #1;
    mir1 = q1.size() < 2;
    mir0 = (q0.size() == 0) || or0;
    if (known) begin
      chk("in_ready1",  ir1, mir1);
      chk("out_valid1", ov1, q1.size() > 0);
      chk("occ1",       oc1, q1.size());
      if (q1.size() > 0) chk("out_data1", od1, q1[0]);
      chk("in_ready0",  ir0, mir0);
      chk("out_valid0", ov0, q0.size() > 0);
      chk("occ0",       oc0, q0.size());
      if (q0.size() > 0) chk("out_data0", od0, q0[0]);
    end
    xi1 = iv1 && mir1;
    xo1 = (q1.size() > 0) && or1;
    xi0 = iv0 && mir0;
    xo0 = (q0.size() > 0) && or0;
    @(posedge clk);
    if (!rst) begin
      q1.delete();
      q0.delete();
      known = 1;
      hold1 = 0;
      hold0 = 0;
    end else begin
      if (xo1) void'(q1.pop_front());
      if (xi1) q1.push_back(id1);
      if (fl1) q1.delete();
      if (xo0) void'(q0.pop_front());
      if (xi0) q0.push_back(id0);
      if (fl0) q0.delete();
      hold1 = iv1 && !xi1;
      hold0 = iv0 && !xi0;
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    fl1 = 0; iv1 = 1; or1 = 1; id1 = 32'hDEADBEEF;
    fl0 = 0; iv0 = 1; or0 = 1; id0 = 32'hDEADBEEF;
    @(negedge clk);

    // Reset held for two cycles with input offered
    cycle();
    cycle();
    rst = 1'b1; iv1 = 0; iv0 = 0;
    #1;
    chk("rst_out_valid1", ov1, 0);
    chk("rst_out_data1",  od1, 32'h0);
    chk("rst_occ1",       oc1, 0);
    chk("rst_in_ready1",  ir1, 1);
    chk("rst_out_valid0", ov0, 0);
    chk("rst_out_data0",  od0, 32'h0);
    chk("rst_in_ready0",  ir0, 1);

    // Streaming 1..8, no bubbles
    or1 = 1;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) begin
        chk("stream_valid", ov1, 1);
        chk("stream_data",  od1, i - 1);
      end
      iv1 = 1; id1 = i;
      cycle();
    end
    iv1 = 0;
    chk("stream_last", od1, 8);
    cycle();
    chk("stream_drained", ov1, 0);

    // Backpressure
    or1 = 0; iv1 = 1; id1 = 32'hA;
    cycle();
    id1 = 32'hB;
    cycle();
    iv1 = 0;
    chk("bp_occ2",     oc1, 2);
    chk("bp_ready0",   ir1, 0);
    chk("bp_head_A",   od1, 32'hA);
    or1 = 1;
    cycle();
    chk("bp_head_B",   od1, 32'hB);
    chk("bp_ready1",   ir1, 1);
    chk("bp_occ1",     oc1, 1);
    cycle();
    chk("bp_empty",    ov1, 0);

    // Flush from two entries, 0x55 offered
    or1 = 0; iv1 = 1; id1 = 32'h11;
    cycle();
    id1 = 32'h22;
    cycle();
    chk("fl_occ2", oc1, 2);
    fl1 = 1; iv1 = 1; id1 = 32'h55;
    cycle();
    fl1 = 0; iv1 = 0;
    chk("fl_valid", ov1, 0);
    chk("fl_occ",   oc1, 0);
    chk("fl_ready", ir1, 1);
    or1 = 1;
    repeat (3) cycle();

    // Flush from one entry: input accepted in flush cycle is discarded
    or1 = 0; iv1 = 1; id1 = 32'h66;
    cycle();
    fl1 = 1; id1 = 32'h77;
    cycle();
    fl1 = 0; iv1 = 0;
    chk("fl1_valid", ov1, 0);
    chk("fl1_occ",   oc1, 0);
    or1 = 1;
    cycle();
    chk("fl1_stays_empty", ov1, 0);

    // Mid-operation reset with two entries
    or1 = 0; iv1 = 1; id1 = 32'hC1;
    cycle();
    id1 = 32'hC2;
    cycle();
    iv1 = 0;
    chk("mr_occ2", oc1, 2);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    chk("mr_valid", ov1, 0);
    chk("mr_occ",   oc1, 0);
    chk("mr_data",  od1, 32'h0);
    chk("mr_ready", ir1, 1);

    // Random traffic on both stages, inputs held while not accepted
    for (int c = 0; c < 10000; c++) begin
      if (!hold1) begin
        iv1 = ($urandom_range(0, 3) != 0);
        id1 = $urandom;
      end
      or1 = ($urandom_range(0, 3) != 0);
      fl1 = ($urandom_range(0, 63) == 0);
      if (!hold0) begin
        iv0 = ($urandom_range(0, 3) != 0);
        id0 = $urandom;
      end
      or0 = ($urandom_range(0, 2) != 0);
      fl0 = 0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
